// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input sync, mid-bit sampling, single-entry
// valid/ready output register with framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e        state_q;
  logic          s1_q, s2_q, prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    sh_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          frame_err_q;
  logic          overrun_q;
  logic          busy_q;

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      sh_q        <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      s1_q        <= rxd;
      s2_q        <= s1_q;
      prev_q      <= s2_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Consumer handshake; a delivery in the same cycle overrides this below.
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);

      case (state_q)
        IDLE: begin
          if (!s2_q && prev_q) begin
            cnt_q   <= HALF_LOAD;
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (!s2_q) begin
              cnt_q   <= BIT_LOAD;
              idx_q   <= 3'd0;
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            sh_q  <= {s2_q, sh_q[7:1]};
            cnt_q <= BIT_LOAD;
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            if (s2_q) begin
              if (!rx_valid_q || rx_ready) begin
                rx_data_q  <= sh_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (s2_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: timing, glitch, framing,
// overrun, same-cycle accept/deliver and mid-frame reset.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int edge_n = 0;

  int   rise_cyc[$];
  logic [7:0] rise_data[$];
  int   fe_rise = 0, fe_hi = 0, ov_rise = 0, ov_hi = 0;
  logic prev_valid = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle and log rx_valid rises and flag pulses.
  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      rise_cyc.push_back(cyc);
      rise_data.push_back(rx_data);
    end
    if (frame_err) fe_hi++;
    if (frame_err && !prev_fe) fe_rise++;
    if (overrun) ov_hi++;
    if (overrun && !prev_ov) ov_rise++;
    prev_valid = rx_valid;
    prev_fe    = frame_err;
    prev_ov    = overrun;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive one frame; optionally pulse rx_ready on the delivery edge or reset mid-frame.
  task automatic send(input logic [7:0] b, input logic stop, input logic pulse_rdy,
                      input int abort_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(negedge clk);
    edge_n = cyc + 1;
    for (int i = 0; i < 10 * CPB; i++) begin
      rxd = fr[i / CPB];
      if (pulse_rdy) rx_ready = (cyc == edge_n + 153);
      if (i == abort_at) begin
        check("busy_before_reset", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({frame_err, overrun}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        rxd  = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  int r0, f0, o0, fh0, oh0, n1, n2;

  initial begin
    rstn     = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    idle(2);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_flags", 32'({frame_err, overrun}), 32'd0);
    rstn = 1'b1;
    idle(5);

    // Back-to-back frames with consumer always ready.
    r0 = rise_cyc.size(); f0 = fe_rise; o0 = ov_rise;
    send(8'h55, 1'b1, 1'b0, -1);
    n1 = edge_n;
    send(8'hA3, 1'b1, 1'b0, -1);
    n2 = edge_n;
    idle(3);
    check("b2b_rises", 32'(rise_cyc.size() - r0), 32'd2);
    check("b2b_data0", 32'(rise_data[r0]), 32'h55);
    check("b2b_time0", 32'(rise_cyc[r0]), 32'(n1 + 154));
    check("b2b_data1", 32'(rise_data[r0+1]), 32'hA3);
    check("b2b_time1", 32'(rise_cyc[r0+1]), 32'(n2 + 154));
    check("b2b_valid_consumed", 32'(rx_valid), 32'd0);
    check("b2b_no_flags", 32'((fe_rise - f0) + (ov_rise - o0)), 32'd0);

    // Three-cycle low glitch on idle line.
    r0 = rise_cyc.size(); f0 = fe_rise; o0 = ov_rise;
    @(negedge clk);
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(3);
    check("glitch_busy_in_start", 32'(busy), 32'd1);
    idle(10);
    check("glitch_back_idle", 32'(busy), 32'd0);
    idle(20);
    check("glitch_no_valid", 32'(rise_cyc.size() - r0), 32'd0);
    check("glitch_no_flags", 32'((fe_rise - f0) + (ov_rise - o0)), 32'd0);

    // Stop bit low followed by a break, then a good frame.
    r0 = rise_cyc.size(); f0 = fe_rise; fh0 = fe_hi;
    send(8'h3C, 1'b0, 1'b0, -1);
    idle(40);
    check("break_busy_wait_high", 32'(busy), 32'd1);
    rxd = 1'b1;
    idle(20);
    check("ferr_pulses", 32'(fe_rise - f0), 32'd1);
    check("ferr_width", 32'(fe_hi - fh0), 32'd1);
    check("ferr_no_valid", 32'(rise_cyc.size() - r0), 32'd0);
    check("ferr_idle", 32'(busy), 32'd0);
    send(8'h81, 1'b1, 1'b0, -1);
    idle(3);
    check("after_ferr_rises", 32'(rise_cyc.size() - r0), 32'd1);
    check("after_ferr_data", 32'(rise_data[rise_data.size()-1]), 32'h81);

    // Overrun: second byte dropped while first is unconsumed.
    rx_ready = 1'b0;
    o0 = ov_rise; oh0 = ov_hi;
    send(8'h11, 1'b1, 1'b0, -1);
    send(8'h22, 1'b1, 1'b0, -1);
    idle(2);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data_kept", 32'(rx_data), 32'h11);
    check("ovr_pulses", 32'(ov_rise - o0), 32'd1);
    check("ovr_width", 32'(ov_hi - oh0), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("accept_clears_valid", 32'(rx_valid), 32'd0);
    check("accept_data_held", 32'(rx_data), 32'h11);

    // Accept and deliver in the same cycle.
    send(8'h11, 1'b1, 1'b0, -1);
    idle(2);
    check("pend_valid", 32'(rx_valid), 32'd1);
    check("pend_data", 32'(rx_data), 32'h11);
    o0 = ov_rise;
    send(8'h22, 1'b1, 1'b1, -1);
    idle(2);
    check("same_cycle_valid", 32'(rx_valid), 32'd1);
    check("same_cycle_data", 32'(rx_data), 32'h22);
    check("same_cycle_no_ovr", 32'(ov_rise - o0), 32'd0);

    // Reset during data bit 4 of 0xF0, then a clean frame.
    send(8'hF0, 1'b1, 1'b0, 5 * CPB + 8);
    idle(5);
    check("post_reset_idle", 32'(busy), 32'd0);
    rx_ready = 1'b1;
    r0 = rise_cyc.size(); f0 = fe_rise; o0 = ov_rise;
    send(8'h0F, 1'b1, 1'b0, -1);
    idle(3);
    check("post_reset_rises", 32'(rise_cyc.size() - r0), 32'd1);
    check("post_reset_data", 32'(rise_data[rise_data.size()-1]), 32'h0F);
    check("post_reset_time", 32'(rise_cyc[rise_cyc.size()-1]), 32'(edge_n + 154));
    check("post_reset_no_flags", 32'((fe_rise - f0) + (ov_rise - o0)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
